counter_preset_sequencer: RTL and testbench

Upstream control stage for the 4-bit loadable up-counter. Accepts a queue of (preset, limit) segment requests over a valid/ready handshake and buffers them in a small FIFO. Drives the counter's `load`/`a` inputs so that each segment starts at its preset and runs until the counter reaches its limit. Watches the counter's `count` output to detect the end of each segment, then reloads the next queued segment back-to-back.

---
 rtl/counter_seq_pkg.sv | 13 +
 rtl/preset_fifo.sv | 62 ++++++
 rtl/upcounter4.sv | 16 +
 rtl/counter_preset_sequencer.sv | 111 +++++++++++
 tb/tb_counter_preset_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and sizing for the counter preset sequencer.
package counter_seq_pkg;

  localparam int unsigned CntW     = 4;
  localparam int unsigned EntryW   = 2 * CntW;
  localparam int unsigned DefDepth = 4;

  typedef enum logic [0:0] {
    S_IDLE,
    S_RUN
  } seq_state_e;

endpackage

// File: rtl/preset_fifo.sv
// Synchronous FIFO of {preset, limit} entries; head is readable combinationally.
module preset_fifo
  import counter_seq_pkg::*;
#(
  parameter int unsigned Width = EntryW,
  parameter int unsigned Depth = DefDepth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             push_ok, pop_ok;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/upcounter4.sv
// 4-bit loadable up-counter driven by the sequencer.
module upcounter4 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] a_i,
  output logic [3:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i)       count_o <= '0;
    else if (load_i) count_o <= a_i;
    else             count_o <= count_o + 4'd1;
  end

endmodule

// File: rtl/counter_preset_sequencer.sv
// Queues (preset, limit) segments and drives a loadable counter through them back-to-back.
module counter_preset_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned W     = CntW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [W-1:0]             req_preset_i,
  input  logic [W-1:0]             req_limit_i,
  input  logic [W-1:0]             count_i,
  output logic                     load_o,
  output logic [W-1:0]             a_o,
  output logic                     seg_done_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  seq_state_e     state_q, state_d;
  logic           load_q, load_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   lim_q, lim_d;
  logic           seg_done_q, seg_done_d;

  logic           full, empty, pop, push;
  logic [2*W-1:0] head;

  assign req_ready_o = !full && !flush_i;
  assign push        = req_valid_i && req_ready_o;

  preset_fifo #(
    .Width (2 * W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i ({req_preset_i, req_limit_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level_o)
  );

  always_comb begin
    state_d    = state_q;
    load_d     = 1'b0;
    a_d        = a_q;
    lim_d      = lim_q;
    seg_done_d = 1'b0;
    pop        = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            load_d  = 1'b1;
            a_d     = head[2*W-1:W];
            lim_d   = head[W-1:0];
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // The load cycle still shows the old count, so compare is skipped.
          if (!load_q && (count_i == lim_q)) begin
            seg_done_d = 1'b1;
            if (!empty) begin
              pop    = 1'b1;
              load_d = 1'b1;
              a_d    = head[2*W-1:W];
              lim_d  = head[W-1:0];
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      load_q     <= 1'b0;
      a_q        <= '0;
      lim_q      <= '0;
      seg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      a_q        <= a_d;
      lim_q      <= lim_d;
      seg_done_q <= seg_done_d;
    end
  end

  assign load_o     = load_q;
  assign a_o        = a_q;
  assign seg_done_o = seg_done_q;
  assign busy_o     = (state_q == S_RUN);

endmodule

// File: tb/tb_counter_preset_sequencer.sv
// Scoreboard bench: sequencer plus upcounter4, directed segment vectors.
module tb_counter_preset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_preset = '0;
  logic [3:0] req_limit = '0;
  logic [3:0] count;
  logic       load;
  logic [3:0] a;
  logic       seg_done;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] preset;
    logic [3:0] limit;
    int         len;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  counter_preset_sequencer #(
    .W     (4),
    .DEPTH (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_preset_i (req_preset),
    .req_limit_i  (req_limit),
    .count_i      (count),
    .load_o       (load),
    .a_o          (a),
    .seg_done_o   (seg_done),
    .busy_o       (busy),
    .fifo_level_o (fifo_level)
  );

  upcounter4 u_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .a_i     (a),
    .count_o (count)
  );

  // Monitor: rebuilds each segment from load/count and checks it on seg_done.
  logic [3:0] seg_preset = '0;
  logic [3:0] last_count = '0;
  logic       prev_load  = 1'b0;
  int         seg_len    = 0;

  always @(negedge clk) begin
    exp_t e;
    if (seg_done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_seg_done: got seg_done=1 at count=%0d, required no pulse",
                 last_count);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (seg_preset != e.preset) begin
          errors++;
          $display("FAIL seg_preset: got %0d, required %0d", seg_preset, e.preset);
        end
        checks++;
        if (last_count != e.limit) begin
          errors++;
          $display("FAIL seg_limit: got %0d, required %0d", last_count, e.limit);
        end
        checks++;
        if (seg_len != e.len) begin
          errors++;
          $display("FAIL seg_len (%0d,%0d): got %0d, required %0d",
                   e.preset, e.limit, seg_len, e.len);
        end
      end
    end
    if (prev_load) begin
      seg_preset = count;
      seg_len    = 1;
    end else begin
      seg_len++;
    end
    last_count = count;
    prev_load  = load;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [3:0] p, input logic [3:0] l, input int len);
    int   n;
    exp_t e;
    n          = 0;
    req_valid  = 1'b1;
    req_preset = p;
    req_limit  = l;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_accept", int'(req_ready), 1);
    if (req_ready) begin
      tick();
      e.preset = p;
      e.limit  = l;
      e.len    = len;
      sb_q.push_back(e);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0 || fifo_level != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(n < 300), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load"}, int'(load), 0);
    chk({tag, "_a"}, int'(a), 0);
    chk({tag, "_seg_done"}, int'(seg_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_level"}, int'(fifo_level), 0);
    chk({tag, "_ready"}, int'(req_ready), 1);
  endtask

  initial begin
    int n;

    // Reset for two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Segment 0..7: load with a=0 the cycle after acceptance.
    push_req(4'd0, 4'd7, 8);
    tick();
    chk("first_load", int'(load), 1);
    chk("first_a", int'(a), 0);
    tick();
    chk("first_count", int'(count), 0);
    wait_idle();
    chk("busy_after_seg", int'(busy), 0);

    // Wrap segment 14,15,0,1.
    push_req(4'd14, 4'd1, 4);
    wait_idle();

    // Back-to-back: seg_done of (2,3) coincides with reload of 9.
    push_req(4'd2, 4'd3, 2);
    push_req(4'd9, 4'd9, 1);
    n = 0;
    @(negedge clk);
    while (!seg_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_seen", int'(seg_done), 1);
    chk("b2b_load", int'(load), 1);
    chk("b2b_a", int'(a), 9);
    tick();
    wait_idle();

    // Long segment with the FIFO filled behind it.
    push_req(4'd0, 4'd15, 16);
    tick();
    tick();
    push_req(4'd1, 4'd2, 2);
    push_req(4'd3, 4'd3, 1);
    push_req(4'd4, 4'd6, 3);
    push_req(4'd15, 4'd0, 2);
    chk("full_level", int'(fifo_level), 4);
    chk("full_ready", int'(req_ready), 0);
    chk("full_busy", int'(busy), 1);
    push_req(4'd8, 4'd11, 4);
    wait_idle();

    // Flush while running with two entries queued.
    push_req(4'd0, 4'd15, 16);
    tick();
    tick();
    push_req(4'd5, 4'd6, 2);
    push_req(4'd7, 4'd8, 2);
    chk("pre_flush_level", int'(fifo_level), 2);
    flush      = 1'b1;
    req_valid  = 1'b1;
    req_preset = 4'd1;
    req_limit  = 4'd1;
    #1;
    chk("flush_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    sb_q.delete();
    chk("flush_busy", int'(busy), 0);
    chk("flush_load", int'(load), 0);
    chk("flush_level", int'(fifo_level), 0);
    chk("flush_seg_done", int'(seg_done), 0);
    repeat (30) tick();
    chk("post_flush_level", int'(fifo_level), 0);

    // Reset mid-segment at count==5, limit 9.
    push_req(4'd3, 4'd9, 7);
    n = 0;
    while (!(busy && !load && count == 4'd5) && n < 50) begin
      tick();
      n++;
    end
    chk("mid_count5", int'(count), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    chk_reset_outputs("midrst");
    chk("midrst_count", int'(count), 0);
    repeat (20) tick();
    chk("post_rst_busy", int'(busy), 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
